// File: rtl/field_writer.sv
// field_writer: raster-paints a bordered, filled box into a FIELD_W x FIELD_H palette-index field.
// Define FIELD_WRITER_CLEAR_EN to sweep the whole field and write 0 outside the box.
module field_writer #(
    parameter int FIELD_W = 165,
    parameter int FIELD_H = 140,
    parameter int ADDR_W  = 20
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [7:0]        box_x0,
    input  logic [7:0]        box_x1,
    input  logic [7:0]        box_y0,
    input  logic [7:0]        box_y1,
    input  logic [3:0]        border_idx,
    input  logic [3:0]        fill_idx,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

    localparam logic [8:0] W_LIM = 9'(FIELD_W);
    localparam logic [8:0] H_LIM = 9'(FIELD_H);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_x0, r_x1, r_y0, r_y1;
    logic [7:0]        r_x, r_y;
    logic [3:0]        r_border, r_fill;
    logic [ADDR_W-1:0] r_rowBase;
    logic              r_err;

    logic              w_accept, w_boxValid, w_step, w_lastPix, w_inside, w_edge;
    logic [7:0]        w_firstX, w_firstY, w_scanX0, w_scanX1, w_scanY1;
    logic [ADDR_W-1:0] w_firstBase;

    assign w_boxValid = (box_x0 <= box_x1) && (box_y0 <= box_y1) &&
                        ({1'b0, box_x1} < W_LIM) && ({1'b0, box_y1} < H_LIM);
    assign w_accept   = (r_state == IDLE) && start;
    assign w_step     = (r_state == SWEEP) && wr_ready;

`ifdef FIELD_WRITER_CLEAR_EN
    assign w_firstX    = 8'd0;
    assign w_firstY    = 8'd0;
    assign w_firstBase = '0;
    assign w_scanX0    = 8'd0;
    assign w_scanX1    = 8'(FIELD_W - 1);
    assign w_scanY1    = 8'(FIELD_H - 1);
`else
    // Starting row base y0*FIELD_W built as a shift-add over the constant's set bits.
    function automatic logic [ADDR_W-1:0] rowBaseOf(input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        logic [31:0]       w;
        acc = '0;
        w   = 32'(FIELD_W);
        for (int i = 0; i < 9; i++) begin
            if (w[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    assign w_firstX    = box_x0;
    assign w_firstY    = box_y0;
    assign w_firstBase = rowBaseOf(box_y0);
    assign w_scanX0    = r_x0;
    assign w_scanX1    = r_x1;
    assign w_scanY1    = r_y1;
`endif

    assign w_lastPix = (r_x == w_scanX1) && (r_y == w_scanY1);
    assign w_inside  = (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1);
    assign w_edge    = (r_x == r_x0) || (r_x == r_x1) || (r_y == r_y0) || (r_y == r_y1);
    assign err       = r_err;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x0      <= 8'd0;
            r_x1      <= 8'd0;
            r_y0      <= 8'd0;
            r_y1      <= 8'd0;
            r_border  <= 4'h0;
            r_fill    <= 4'h0;
            r_x       <= 8'd0;
            r_y       <= 8'd0;
            r_rowBase <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_x0      <= box_x0;
            r_x1      <= box_x1;
            r_y0      <= box_y0;
            r_y1      <= box_y1;
            r_border  <= border_idx;
            r_fill    <= fill_idx;
            r_x       <= w_firstX;
            r_y       <= w_firstY;
            r_rowBase <= w_firstBase;
            r_err     <= !w_boxValid;
        end else if (w_step) begin
            // The row step past the final pixel is harmless: outputs are gated outside SWEEP.
            if (r_x == w_scanX1) begin
                r_x       <= w_scanX0;
                r_y       <= r_y + 8'd1;
                r_rowBase <= r_rowBase + ADDR_W'(FIELD_W);
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = 4'h0;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = w_boxValid ? SWEEP : FINISH;
            end
            SWEEP: begin
                wr_en   = 1'b1;
                busy    = 1'b1;
                wr_addr = r_rowBase + ADDR_W'(r_x);
                wr_data = w_inside ? (w_edge ? r_border : r_fill) : 4'h0;
                if (wr_ready && w_lastPix) w_next = FINISH;
            end
            FINISH: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
